// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes and FSM states.
package muldiv_unit_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring divide step: shift the next dividend bit into the remainder, subtract if it fits.
module muldiv_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic           fits;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    fits     = shifted >= {1'b0, divisor};
    rem_next = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide owning the HI/LO registers.
// MULDIV_FAST_MUL_EN selects a single-cycle combinational multiply; divides stay iterative.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opd;
  logic             div_op, neg_res, neg_rem, dz;
  logic             load, step, fix_wr, fast_wr;

  logic             in_div, in_neg_a, in_neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] ds_rem, ds_quo;
  logic [WIDTH:0]   mul_sum;
  logic [ACC_W-1:0] prod, fast_prod;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Operand magnitudes and signs for the incoming request
  always_comb begin
    in_div   = op_is_div(op);
    in_neg_a = op_is_signed(op) & a[WIDTH-1];
    in_neg_b = op_is_signed(op) & b[WIDTH-1];
    abs_a    = in_neg_a ? -a : a;
    abs_b    = in_neg_b ? -b : b;
  end

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod = (in_neg_a ^ in_neg_b) ? -(ACC_W'(abs_a) * ACC_W'(abs_b))
                                           :  (ACC_W'(abs_a) * ACC_W'(abs_b));
`else
  assign fast_prod = '0;
`endif

  muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem      (acc_hi),
    .quo      (acc_lo),
    .divisor  (opd),
    .rem_next (ds_rem),
    .quo_next (ds_quo)
  );

  // Shift-add: conditionally add multiplicand to the upper half, then shift the pair right
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);

  // Sign correction; a zero divisor forces an all-ones quotient and leaves the dividend in HI
  always_comb begin
    prod = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (div_op) begin
      res_lo = dz ? '1 : (neg_res ? -acc_lo : acc_lo);
      res_hi = neg_rem ? -acc_hi : acc_hi;
    end else begin
      res_hi = prod[ACC_W-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    fix_wr   = 1'b0;
    fast_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (FAST_MUL && !in_div) begin
            fast_wr = 1'b1;
          end else begin
            load     = 1'b1;
            state_nx = CALC;
          end
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
      end
      FIX: begin
        fix_wr   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Flush overrides everything, including a start in the same cycle
    if (cancel) begin
      state_nx = IDLE;
      load     = 1'b0;
      step     = 1'b0;
      fix_wr   = 1'b0;
      fast_wr  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opd      <= '0;
      div_op   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
    end else begin
      busy     <= (state_nx != IDLE);
      done     <= fix_wr | fast_wr;
      div_zero <= fix_wr & dz;
      if (!busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      // Result writes come last so they win over a same-edge MTHI/MTLO
      if (fix_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (fast_wr) begin
        hi <= fast_prod[ACC_W-1:WIDTH];
        lo <= fast_prod[WIDTH-1:0];
      end
      if (load) begin
        cnt     <= '0;
        acc_hi  <= '0;
        acc_lo  <= in_div ? abs_a : abs_b;
        opd     <= in_div ? abs_b : abs_a;
        div_op  <= in_div;
        neg_res <= in_neg_a ^ in_neg_b;
        neg_rem <= in_neg_a;
        dz      <= in_div && (b == '0);
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
        if (div_op) begin
          acc_hi <= ds_rem;
          acc_lo <= ds_quo;
        end else begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, flush/MTHI cases and random ops vs an arithmetic model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, cancel, hi_we, lo_we;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wdata;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .cancel   (cancel),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference result {div_zero, hi, lo} from plain 64-bit arithmetic
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_MULTU: begin
        p = {32'h0, x} * {32'h0, y};
        return {1'b0, p};
      end
      OP_MULT: begin
        q = sx * sy;
        return {1'b0, q};
      end
      default: begin
        if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o == OP_DIVU) return {1'b0, x % y, x / y};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called in cycle 0 (just after an edge); returns in the done cycle
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [64:0] e;
    int          lat, cyc;
    bit          seen, busy_ok;
    e   = model(o, x, y);
    lat = (FAST && !o[1]) ? 1 : W + 2;
    start = 1'b1; op = o; a = x; b = y;
    cyc = 0; seen = 0; busy_ok = 1;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1) busy_ok = 0;
    end
    chk({tag, ".latency"}, seen ? cyc : 0, lat);
    chk({tag, ".busy_during"}, busy_ok, 1);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".hi"}, hi, e[63:32]);
    chk({tag, ".lo"}, lo, e[31:0]);
    chk({tag, ".div_zero"}, div_zero, e[64]);
  endtask

  initial begin
    bit          busy_hi, busy_lo, done_seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.hi", hi, 0);
    chk("reset.lo", lo, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.div_zero", div_zero, 0);

    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max.hi_vec", hi, 32'hFFFF_FFFE);
    chk("multu_max.lo_vec", lo, 32'h0000_0001);
    idle(2);

    do_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5);
    chk("mult_neg.lo_vec", lo, 32'hFFFF_FFF1);
    do_op("divu_b2b", OP_DIVU, 32'd7, 32'd2);
    chk("divu_b2b.lo_vec", lo, 32'd3);
    chk("divu_b2b.hi_vec", hi, 32'd1);
    idle(1);

    do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg.lo_vec", lo, 32'hFFFF_FFFD);
    chk("div_neg.hi_vec", hi, 32'hFFFF_FFFF);
    idle(1);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf.lo_vec", lo, 32'h8000_0000);
    idle(1);

    do_op("divu_zero", OP_DIVU, 32'd5, 32'd0);
    chk("divu_zero.dz_vec", div_zero, 1);
    idle(1);
    chk("divu_zero.dz_after", div_zero, 0);
    chk("divu_zero.done_after", done, 0);
    do_op("div_zero", OP_DIV, 32'd5, 32'd0);
    chk("div_zero.lo_vec", lo, 32'hFFFF_FFFF);
    idle(1);
    do_op("div_negzero", OP_DIV, 32'hFFFF_FFF0, 32'd0);
    idle(2);

    // MTHI/MTLO, then a divide flushed in cycle 10 with a stray start and MTHI while busy
    hi_we = 1'b1; wdata = 32'h11;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("mt.hi", hi, 32'h11);
    chk("mt.lo", lo, 32'h22);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3;
    busy_hi = 1; busy_lo = 1; done_seen = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; cancel = 1'b0;
      if (c <= 10) begin
        if (busy !== 1'b1) busy_hi = 0;
      end else begin
        if (busy !== 1'b0) busy_lo = 0;
      end
      if (done === 1'b1) done_seen = 1;
      if (c == 5) begin start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2; end
      if (c == 6) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h99; end
      if (c == 10) cancel = 1'b1;
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen = 1;
    end
    chk("cancel.busy_before", busy_hi, 1);
    chk("cancel.busy_after", busy_lo, 1);
    chk("cancel.no_done", done_seen, 0);
    chk("cancel.hi", hi, 32'h11);
    chk("cancel.lo", lo, 32'h22);

    // Cancel and start together in IDLE: start is dropped
    start = 1'b1; cancel = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start.busy", busy, 0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen = 1;
    end
    chk("cancel_start.no_done", done_seen, 0);
    chk("cancel_start.lo", lo, 32'h22);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      do_op($sformatf("rnd%0d", i), ro, ra, rb);
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    // Asynchronous reset mid-CALC, between clock edges
    idle(1);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("arst.busy_pre", busy, 1);
    chk("arst.hi_pre", hi, 32'h5A5A);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.done", done, 0);
    chk("arst.hi", hi, 0);
    chk("arst.lo", lo, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst.busy_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
